// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO burst reader: the read-side FSM state encoding.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/skid_fifo.sv
// Small register-based output buffer that absorbs FIFO read latency so the
// reader can sustain one word per cycle under downstream backpressure.
module skid_fifo #(
    parameter int pDATA_WIDTH = 8,
    parameter int pSKID_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push_i,
    input  logic [pDATA_WIDTH-1:0]               push_data_i,
    input  logic                                 pop_i,
    output logic [pDATA_WIDTH-1:0]               head_o,
    output logic [$clog2(pSKID_DEPTH+1)-1:0]     occ_o,
    output logic                                 full_o,
    output logic                                 empty_o
);

    localparam int PTR_W = $clog2(pSKID_DEPTH);
    localparam int OCC_W = $clog2(pSKID_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(pSKID_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(pSKID_DEPTH);

    logic [pDATA_WIDTH-1:0] mem_q [pSKID_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [OCC_W-1:0]       occ_q;
    logic                   push_ok;
    logic                   pop_ok;

    assign full_o  = (occ_q == DEPTH_OCC);
    assign empty_o = (occ_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;

    genvar gi;
    generate
        for (gi = 0; gi < pSKID_DEPTH; gi++) begin : g_slot
            // Each slot loads only when the write pointer addresses it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    // Pointers wrap at the depth (which need not be a power of two);
    // a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for the line FIFO: pops fixed-length bursts, re-times the
// returning words through a small buffer into a valid/ready stream, flags the
// last word and pulses done once the whole burst has been accepted.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int pDATA_WIDTH = 8,
    parameter int pBURST_LEN  = 64,
    parameter int pSKID_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 fifo_rd_en,
    input  logic [pDATA_WIDTH-1:0]               fifo_rd_data,
    input  logic                                 fifo_valid,
    input  logic                                 fifo_empty,
    output logic [pDATA_WIDTH-1:0]               m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_last,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(pBURST_LEN+1)-1:0]      word_cnt,
    output logic                                 err
);

    localparam int CNT_W = $clog2(pBURST_LEN + 1);
    localparam int OCC_W = $clog2(pSKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] LEN_C      = CNT_W'(pBURST_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(pBURST_LEN - 1);
    localparam logic [OCC_W:0]   DEPTH_C    = (OCC_W + 1)'(pSKID_DEPTH);

    rd_state_e          state_q;
    logic [CNT_W-1:0]   issued_cnt_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               inflight_q;
    logic               err_q;

    logic [OCC_W-1:0]   occ;
    logic               buf_full;
    logic               buf_empty;
    logic [OCC_W:0]     credit_used;
    logic               push;
    logic               xfer;

    // Entries already held plus the word still returning from the FIFO;
    // a new pop is only issued if it is guaranteed a free slot.
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};

    // Pops depend only on registered state and the FIFO empty flag, never on
    // m_ready. Gating with rst_n keeps a reset cycle from popping a word that
    // would then arrive with no outstanding request.
    assign fifo_rd_en = rst_n
                      & (state_q == READ)
                      & ~fifo_empty
                      & (issued_cnt_q < LEN_C)
                      & (credit_used < DEPTH_C);

    assign push     = fifo_valid & inflight_q & ~buf_full;
    assign m_valid  = ~buf_empty;
    assign xfer     = m_valid & m_ready;
    assign m_last   = m_valid & (word_cnt_q == LAST_IDX_C);
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;
    assign err      = err_q;

    skid_fifo #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pSKID_DEPTH (pSKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (fifo_rd_data),
        .pop_i       (xfer),
        .head_o      (m_data),
        .occ_o       (occ),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    // Burst FSM with its counters and registered busy/done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            issued_cnt_q <= '0;
            word_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fifo_rd_en) begin
                issued_cnt_q <= issued_cnt_q + CNT_W'(1);
            end
            if (xfer) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= READ;
                        issued_cnt_q <= '0;
                        word_cnt_q   <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                READ: begin
                    if (issued_cnt_q == LEN_C) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer && m_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Track the outstanding pop and latch protocol errors until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (fifo_valid && (!inflight_q || buf_full)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scenario bench for fifo_burst_reader: behavioural source FIFO, expected-word
// scoreboard on the stream side, one task per scenario.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    localparam int LEN = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_valid;
    logic       fifo_empty;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       busy;
    logic       done;
    logic [6:0] word_cnt;
    logic       err;

    logic       mdl_valid = 1'b0;
    logic       force_valid;
    logic       fifo_clr;
    logic [7:0] fmem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         sb_idx = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_w;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .pDATA_WIDTH (8),
        .pBURST_LEN  (LEN),
        .pSKID_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_valid   (fifo_valid),
        .fifo_empty   (fifo_empty),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
        .word_cnt     (word_cnt),
        .err          (err)
    );

    // Source FIFO model: data and valid return one cycle after a pop.
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_valid = mdl_valid | force_valid;

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr    <= wr_ptr;
            mdl_valid <= 1'b0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fmem[rd_ptr % 1024];
            rd_ptr       <= rd_ptr + 1;
            mdl_valid    <= 1'b1;
        end else begin
            mdl_valid <= 1'b0;
        end
    end

    // Scoreboard: every accepted word must be the next expected one, m_last
    // must mark word LEN-1, and a stalled word must hold its value.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            sb_idx     = 0;
            prev_stall = 1'b0;
        end else begin
            if (start && !busy && !done) sb_idx = 0;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: valid=%b data=%02h required valid=1 data=%02h", m_valid, m_data, prev_data);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %02h with nothing expected", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (m_data !== exp_w || m_last !== (sb_idx == LEN - 1)) begin
                        errors++;
                        $display("FAIL word%0d: data=%02h last=%b required data=%02h last=%b",
                                 sb_idx, m_data, m_last, exp_w, (sb_idx == LEN - 1));
                    end else begin
                        $display("word %0d data=%02h last=%b", sb_idx, m_data, m_last);
                    end
                end
                sb_idx++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        fmem[wr_ptr % 1024] = v;
        wr_ptr++;
        exp_q.push_back(v);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        fifo_clr = 1'b1;
        tick();
        tick();
        rst_n    = 1'b1;
        fifo_clr = 1'b0;
    endtask

    // Runs the stream for up to budget cycles (optionally issuing start and
    // extra start pulses) and reports what it observed; stops 8 cycles after done.
    task automatic run_burst(input int budget, input bit do_start, input bit toggle,
                             input int restart_cyc, input bit start_on_done,
                             output int ndone, output int first_rd, output int first_v,
                             output int last_x, output int done_cyc, output int nx,
                             output int max_occ, output bit timeout);
        ndone = 0; first_rd = -1; first_v = -1; last_x = -1; done_cyc = -1;
        nx = 0; max_occ = 0; timeout = 1'b1;
        m_ready = 1'b1;
        if (do_start) start = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            start = 1'b0;
            if (fifo_rd_en && first_rd < 0) first_rd = c;
            if (m_valid && first_v < 0) first_v = c;
            if (int'(dut.u_skid.occ_o) > max_occ) max_occ = int'(dut.u_skid.occ_o);
            if (m_valid && m_ready) begin
                nx++;
                last_x = c;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
                if (start_on_done) start = 1'b1;
            end
            if (c == restart_cyc) start = 1'b1;
            if (done_cyc >= 0 && c >= done_cyc + 8) begin
                timeout = 1'b0;
                break;
            end
            if (toggle) m_ready = ~m_ready;
        end
        start   = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fifo_rd_en, m_valid, m_last, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: rd_en,valid,last,busy,done,err=%b required 000000",
                     {fifo_rd_en, m_valid, m_last, busy, done, err});
        end
        checks++;
        if (word_cnt !== 7'd0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: word_cnt=%0d m_data=%02h required 0 00", word_cnt, m_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required IDLE", dut.state_q);
        end
        $display("reset: flags and counters checked");
    endtask

    task automatic test_back_to_back();
        int nd, frd, fv, lx, dc, nx, mo;
        bit to;
        for (int i = 0; i < LEN; i++) push_word(8'(i));
        run_burst(300, 1'b1, 1'b0, -1, 1'b0, nd, frd, fv, lx, dc, nx, mo, to);
        checks++;
        if (to || nd != 1 || nx != LEN) begin
            errors++;
            $display("FAIL b2b_count: timeout=%b dones=%0d words=%0d required 0 1 %0d", to, nd, nx, LEN);
        end
        checks++;
        if (frd != 0 || fv != frd + 2) begin
            errors++;
            $display("FAIL b2b_latency: first_rd=%0d first_valid=%0d required 0 2", frd, fv);
        end
        checks++;
        if (lx - fv != LEN - 1 || dc != lx + 1) begin
            errors++;
            $display("FAIL b2b_rate: span=%0d done_at=%0d required span=%0d done_at=%0d", lx - fv, dc, LEN - 1, lx + 1);
        end
        checks++;
        if (err !== 1'b0 || exp_q.size() != 0 || word_cnt !== 7'd64) begin
            errors++;
            $display("FAIL b2b_end: err=%b left=%0d word_cnt=%0d required 0 0 64", err, exp_q.size(), word_cnt);
        end
        $display("back_to_back: words=%0d first_rd=%0d first_valid=%0d done_at=%0d", nx, frd, fv, dc);
    endtask

    task automatic test_backpressure();
        int nd, frd, fv, lx, dc, nx, mo;
        bit to;
        for (int i = 0; i < LEN; i++) push_word(8'(i) ^ 8'h5a);
        run_burst(500, 1'b1, 1'b1, -1, 1'b0, nd, frd, fv, lx, dc, nx, mo, to);
        checks++;
        if (to || nd != 1 || nx != LEN || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: timeout=%b dones=%0d words=%0d left=%0d required 0 1 %0d 0", to, nd, nx, exp_q.size(), LEN);
        end
        checks++;
        if (mo > 4 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_occ: max_occ=%0d err=%b required <=4 0", mo, err);
        end
        $display("backpressure: words=%0d max_occ=%0d", nx, mo);
    endtask

    task automatic test_underflow();
        int nd, frd, fv, lx, dc, nx, mo;
        bit to;
        for (int i = 0; i < 10; i++) push_word(8'(8'h80 + i));
        run_burst(40, 1'b1, 1'b0, -1, 1'b0, nd, frd, fv, lx, dc, nx, mo, to);
        checks++;
        if (!to || nx != 10 || busy !== 1'b1 || word_cnt !== 7'd10 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL uf_stall: ended=%b words=%0d busy=%b word_cnt=%0d empty=%b required 0 10 1 10 1",
                     !to, nx, busy, word_cnt, fifo_empty);
        end
        for (int i = 10; i < LEN; i++) push_word(8'(8'h80 + i));
        run_burst(300, 1'b0, 1'b0, -1, 1'b0, nd, frd, fv, lx, dc, nx, mo, to);
        checks++;
        if (to || nd != 1 || nx != LEN - 10 || word_cnt !== 7'd64 || exp_q.size() != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL uf_resume: timeout=%b dones=%0d words=%0d word_cnt=%0d left=%0d err=%b required 0 1 54 64 0 0",
                     to, nd, nx, word_cnt, exp_q.size(), err);
        end
        $display("underflow: resumed words=%0d word_cnt=%0d", nx, word_cnt);
    endtask

    task automatic test_start_while_busy();
        int nd, frd, fv, lx, dc, nx, mo;
        bit to;
        for (int i = 0; i < LEN; i++) push_word(8'(255 - i));
        run_burst(300, 1'b1, 1'b0, 5, 1'b1, nd, frd, fv, lx, dc, nx, mo, to);
        checks++;
        if (to || nd != 1 || nx != LEN || exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_start_count: timeout=%b dones=%0d words=%0d left=%0d required 0 1 %0d 0", to, nd, nx, exp_q.size(), LEN);
        end
        checks++;
        if (busy !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL busy_start_idle: busy=%b state=%0d required 0 IDLE", busy, dut.state_q);
        end
        $display("start_while_busy: dones=%0d words=%0d", nd, nx);
    endtask

    task automatic test_reset_mid_burst();
        int nd, frd, fv, lx, dc, nx, mo;
        bit to;
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < LEN; i++) push_word(8'(i * 3 + 1));
        m_ready = 1'b1;
        start   = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            start = 1'b0;
            if (word_cnt == 7'd20) begin
                reached = 1'b1;
                break;
            end
        end
        m_ready = 1'b0;
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rst_mid_reach: word_cnt=%0d required 20 within budget", word_cnt);
        end
        tick();
        do_reset();
        m_ready = 1'b1;
        checks++;
        if ({fifo_rd_en, m_valid, m_last, busy, done, err} !== 6'b0 || word_cnt !== 7'd0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_outputs: flags=%b word_cnt=%0d m_data=%02h required 000000 0 00",
                     {fifo_rd_en, m_valid, m_last, busy, done, err}, word_cnt, m_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_state: state=%0d required IDLE", dut.state_q);
        end
        for (int i = 0; i < LEN; i++) push_word(8'(i * 5 + 2));
        run_burst(300, 1'b1, 1'b0, -1, 1'b0, nd, frd, fv, lx, dc, nx, mo, to);
        checks++;
        if (to || nd != 1 || nx != LEN || exp_q.size() != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fresh: timeout=%b dones=%0d words=%0d left=%0d err=%b required 0 1 %0d 0 0",
                     to, nd, nx, exp_q.size(), err, LEN);
        end
        $display("reset_mid_burst: fresh words=%0d", nx);
    endtask

    task automatic test_error();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: err=%b required 0", err);
        end
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b required 1", err);
        end
        repeat (5) tick();
        checks++;
        if (err !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: err=%b m_valid=%b required 1 0", err, m_valid);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
        $display("error: spurious valid latched and cleared by reset");
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        m_ready     = 1'b1;
        force_valid = 1'b0;
        fifo_clr    = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_underflow();
        test_start_while_busy();
        test_reset_mid_burst();
        test_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
